// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: holds the 8x8 cost table and shares it between two
// search engines. It also merges each engine's min-cost and match-count results.
module jam_cost_arbiter #(
    parameter int N_REQ  = 2,
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    LD_VALID,
    input  logic [COST_W-1:0]       LD_DATA,
    output logic                    LD_READY,
    input  logic                    START,
    input  logic                    RELOAD,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*IDX_W-1:0]  REQ_W,
    input  logic [N_REQ*IDX_W-1:0]  REQ_J,
    output logic [N_REQ-1:0]        GNT,
    output logic [N_REQ-1:0]        RSP_VALID,
    output logic [COST_W-1:0]       COST,
    input  logic [N_REQ-1:0]        ENG_DONE,
    input  logic [N_REQ*10-1:0]     ENG_MIN,
    input  logic [N_REQ*4-1:0]      ENG_CNT,
    output logic [9:0]              MinCost,
    output logic [3:0]              MatchCount,
    output logic                    Valid
);

    localparam int AW = 2 * IDX_W;

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        RUN,
        MERGE,
        OUT
    } state_t;

    state_t            state;
    logic [COST_W-1:0] tbl [2**AW];
    logic [AW-1:0]     ld_addr;
    logic              rr_ptr;
    logic [1:0]        done;
    logic [9:0]        min0, min1;
    logic [3:0]        cnt0, cnt1;

    logic [1:0]        elig;
    logic [1:0]        gnt_c;
    logic [1:0]        done_set;
    logic [1:0]        done_nxt;
    logic [AW-1:0]     rd_addr;
    logic [4:0]        cnt_sum;

    // rr_ptr=0 favours engine 0; done engines drop out of arbitration
    always_comb begin
        elig  = REQ & ~done;
        gnt_c = 2'b00;
        if (state == RUN) begin
            if (elig == 2'b11)
                gnt_c = rr_ptr ? 2'b10 : 2'b01;
            else
                gnt_c = elig;
        end
        rd_addr = gnt_c[1] ? {REQ_W[2*IDX_W-1:IDX_W], REQ_J[2*IDX_W-1:IDX_W]}
                           : {REQ_W[IDX_W-1:0], REQ_J[IDX_W-1:0]};
        done_set = (state == RUN) ? (ENG_DONE & ~done) : 2'b00;
        done_nxt = done | done_set;
        cnt_sum  = {1'b0, cnt0} + {1'b0, cnt1};
    end

    assign GNT      = gnt_c;
    assign LD_READY = (state == LOAD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2**AW; i++)
                tbl[i] <= '0;
        end else if (state == LOAD && LD_VALID) begin
            tbl[ld_addr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= LOAD;
            ld_addr    <= '0;
            rr_ptr     <= 1'b0;
            done       <= 2'b00;
            min0       <= '0;
            min1       <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            RSP_VALID  <= '0;
            COST       <= '0;
            MinCost    <= 10'h3FF;
            MatchCount <= '0;
            Valid      <= 1'b0;
        end else begin
            RSP_VALID <= gnt_c;
            if (gnt_c != 2'b00) begin
                COST   <= tbl[rd_addr];
                rr_ptr <= gnt_c[0];
            end
            unique case (state)
                LOAD: begin
                    if (LD_VALID) begin
                        ld_addr <= ld_addr + 1'b1;
                        if (&ld_addr)
                            state <= ARM;
                    end
                end
                ARM: begin
                    if (RELOAD) begin
                        state   <= LOAD;
                        ld_addr <= '0;
                    end else if (START) begin
                        state <= RUN;
                        done  <= 2'b00;
                    end
                end
                RUN: begin
                    done <= done_nxt;
                    if (done_set[0]) begin
                        min0 <= ENG_MIN[9:0];
                        cnt0 <= ENG_CNT[3:0];
                    end
                    if (done_set[1]) begin
                        min1 <= ENG_MIN[19:10];
                        cnt1 <= ENG_CNT[7:4];
                    end
                    if (&done_nxt)
                        state <= MERGE;
                end
                MERGE: begin
                    if (min0 < min1) begin
                        MinCost    <= min0;
                        MatchCount <= cnt0;
                    end else if (min1 < min0) begin
                        MinCost    <= min1;
                        MatchCount <= cnt1;
                    end else begin
                        MinCost    <= min0;
                        MatchCount <= cnt_sum[4] ? 4'd15 : cnt_sum[3:0];
                    end
                    Valid <= 1'b1;
                    state <= OUT;
                end
                OUT: begin
                    if (RELOAD) begin
                        Valid   <= 1'b0;
                        state   <= LOAD;
                        ld_addr <= '0;
                    end else if (START) begin
                        Valid <= 1'b0;
                        done  <= 2'b00;
                        state <= RUN;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: scoreboard bench for the shared cost-table arbiter.
// It models the table and the round-robin pointer to predict grants and costs.
module tb_jam_cost_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LD_VALID;
    logic [6:0]  LD_DATA;
    logic        LD_READY;
    logic        START;
    logic        RELOAD;
    logic [1:0]  REQ;
    logic [5:0]  REQ_W;
    logic [5:0]  REQ_J;
    logic [1:0]  GNT;
    logic [1:0]  RSP_VALID;
    logic [6:0]  COST;
    logic [1:0]  ENG_DONE;
    logic [19:0] ENG_MIN;
    logic [7:0]  ENG_CNT;
    logic [9:0]  MinCost;
    logic [3:0]  MatchCount;
    logic        Valid;

    int n_chk = 0;
    int n_err = 0;

    logic [6:0] m_tbl [64];
    logic [6:0] sb [$];
    logic       m_ptr = 1'b0;
    logic [1:0] exp_rsp = 2'b00;
    logic       mon_en = 1'b0;

    jam_cost_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
        .START(START), .RELOAD(RELOAD),
        .REQ(REQ), .REQ_W(REQ_W), .REQ_J(REQ_J),
        .GNT(GNT), .RSP_VALID(RSP_VALID), .COST(COST),
        .ENG_DONE(ENG_DONE), .ENG_MIN(ENG_MIN), .ENG_CNT(ENG_CNT),
        .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_chk(input string pfx);
        chk({pfx, "_ld_ready"}, LD_READY, 1);
        chk({pfx, "_gnt"}, GNT, 0);
        chk({pfx, "_rsp_valid"}, RSP_VALID, 0);
        chk({pfx, "_cost"}, COST, 0);
        chk({pfx, "_min"}, MinCost, 10'h3FF);
        chk({pfx, "_cnt"}, MatchCount, 0);
        chk({pfx, "_valid"}, Valid, 0);
    endtask

    function automatic logic [1:0] pick(input logic [1:0] r, input logic p);
        if (r == 2'b11)
            return p ? 2'b10 : 2'b01;
        return r;
    endfunction

    // grant/response scoreboard for lookup phases
    always @(negedge CLK) begin
        if (mon_en) begin
            logic [1:0] eg;
            logic [5:0] a;
            eg = pick(REQ, m_ptr);
            chk("gnt", GNT, eg);
            chk("rsp_valid", RSP_VALID, exp_rsp);
            if (RSP_VALID != 2'b00) begin
                if (sb.size() == 0)
                    chk("sb_underflow", 1, 0);
                else
                    chk("cost", COST, sb.pop_front());
            end
            if (eg != 2'b00) begin
                a = eg[1] ? {REQ_W[5:3], REQ_J[5:3]} : {REQ_W[2:0], REQ_J[2:0]};
                sb.push_back(m_tbl[a]);
                m_ptr = eg[0];
            end
            exp_rsp = eg;
        end
    end

    initial begin
        RST_N = 1'b0; LD_VALID = 0; LD_DATA = 0; START = 0; RELOAD = 0;
        REQ = 0; REQ_W = 0; REQ_J = 0; ENG_DONE = 0; ENG_MIN = 0; ENG_CNT = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset_chk("rst");
        tick;
        RST_N = 1'b1;

        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                LD_VALID = 0;
                repeat (3) tick;
            end
            if (i == 63)
                chk("ld_ready_last", LD_READY, 1);
            m_tbl[i] = 7'(i % 100);
            LD_VALID = 1;
            LD_DATA  = m_tbl[i];
            tick;
        end
        LD_VALID = 0;
        @(negedge CLK);
        chk("ld_ready_arm", LD_READY, 0);

        tick;
        START = 1; mon_en = 1; exp_rsp = 0;
        tick;
        START = 0;
        REQ = 2'b11; REQ_W = {3'd7, 3'd2}; REQ_J = {3'd0, 3'd5};
        repeat (6) tick;
        REQ = 2'b01; REQ_W = {3'd0, 3'd7}; REQ_J = {3'd0, 3'd7};
        tick;
        REQ_W = {3'd0, 3'd1}; REQ_J = {3'd0, 3'd2};
        tick;
        REQ = 2'b00;
        repeat (2) tick;
        mon_en = 0;
        chk("sb_empty", sb.size(), 0);

        ENG_MIN = {10'd300, 10'd300}; ENG_CNT = {4'd14, 4'd2}; ENG_DONE = 2'b11;
        tick;
        ENG_DONE = 0; REQ = 2'b11;
        @(negedge CLK);
        chk("valid_merge", Valid, 0);
        @(negedge CLK);
        chk("eq_valid", Valid, 1);
        chk("eq_min", MinCost, 300);
        chk("eq_cnt_sat", MatchCount, 15);
        chk("gnt_out", GNT, 0);
        REQ = 0;

        tick;
        START = 1;
        tick;
        START = 0;
        @(negedge CLK);
        chk("valid_restart", Valid, 0);

        tick;
        REQ = 2'b01; REQ_W = 0; REQ_J = 0;
        ENG_MIN[9:0] = 10'd250; ENG_CNT[3:0] = 4'd3; ENG_DONE = 2'b01;
        tick;
        ENG_DONE = 0;
        @(negedge CLK);
        chk("gnt_done_eng", GNT, 0);
        tick;
        ENG_MIN[9:0] = 10'd999; ENG_CNT[3:0] = 4'd9; ENG_DONE = 2'b01;
        tick;
        ENG_DONE = 0;
        @(negedge CLK);
        chk("valid_half_done", Valid, 0);
        tick;
        tick;
        ENG_MIN[19:10] = 10'd240; ENG_CNT[7:4] = 4'd1; ENG_DONE = 2'b10;
        tick;
        ENG_DONE = 0; REQ = 0;
        @(negedge CLK);
        @(negedge CLK);
        chk("stag_valid", Valid, 1);
        chk("stag_min", MinCost, 240);
        chk("stag_cnt", MatchCount, 1);

        tick;
        START = 1;
        tick;
        START = 0;
        REQ = 2'b10; REQ_W = {3'd7, 3'd0}; REQ_J = {3'd7, 3'd0};
        @(negedge CLK);
        chk("rerun_valid", Valid, 0);
        chk("rerun_gnt", GNT, 2'b10);
        tick;
        @(negedge CLK);
        chk("rerun_rsp", RSP_VALID, 2'b10);
        chk("rerun_cost63", COST, 63);

        tick;
        RST_N = 0;
        #1;
        reset_chk("midrst");
        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
